// File: rtl/key_event.sv
// Key event decoder: turns a debounced key level into press/release/long/repeat pulses plus a hold timer.
// Define KEY_EVENT_REPEAT_EN to build the auto-repeat counter; otherwise repeat_o is tied low.
module key_event #(
  parameter int   CLK_FREQ_Hz    = 27000000,
  parameter logic RELEASED_LEVEL = 1'b0,
  parameter int   LONG_MS        = 1000,
  parameter int   REPEAT_MS      = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_db_i,
  output logic        press_o,
  output logic        release_o,
  output logic        long_o,
  output logic        repeat_o,
  output logic        pressed_o,
  output logic [15:0] hold_ms_o,
  output logic [1:0]  state_o
);

  localparam int              CPM     = CLK_FREQ_Hz / 1000;
  localparam int              PW      = (CPM > 1) ? $clog2(CPM) : 1;
  localparam logic [PW-1:0]   PS_MAX  = PW'(CPM - 1);
  localparam logic [15:0]     LONG_M1 = 16'(LONG_MS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, sync2_q, edge_q;
  logic [PW-1:0] ps_q, ps_d;
  logic [15:0]   hold_q, hold_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          pressed_q, pressed_d;
  logic          press_ev, release_ev, tick, active;

`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [15:0] REP_M1 = 16'(REPEAT_MS - 1);
  logic [15:0] rep_q, rep_d;
  logic        repeat_q, repeat_d;
`else
  logic unused_repeat_ms;
  assign unused_repeat_ms = ^REPEAT_MS;
`endif

  // Edges are judged between the last synchronizer stage and the edge register.
  assign press_ev   = (sync2_q != RELEASED_LEVEL) && (edge_q == RELEASED_LEVEL);
  assign release_ev = (sync2_q == RELEASED_LEVEL) && (edge_q != RELEASED_LEVEL);
  assign active     = (state_q != IDLE);
  assign tick       = active && (ps_q == PS_MAX);

  always_comb begin
    state_d   = state_q;
    ps_d      = ps_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    pressed_d = pressed_q;
`ifdef KEY_EVENT_REPEAT_EN
    rep_d     = rep_q;
    repeat_d  = 1'b0;
`endif
    if (active) begin
      ps_d = tick ? '0 : ps_q + 1'b1;
      if (tick && (hold_q != 16'hFFFF)) hold_d = hold_q + 16'd1;
    end
    case (state_q)
      IDLE: begin
        if (press_ev) begin
          state_d   = PRESSED;
          press_d   = 1'b1;
          pressed_d = 1'b1;
          ps_d      = '0;
          hold_d    = '0;
        end
      end
      PRESSED: begin
        // Release has priority over the long threshold landing in the same cycle.
        if (release_ev) begin
          state_d   = IDLE;
          release_d = 1'b1;
          pressed_d = 1'b0;
        end else if (tick && (hold_q == LONG_M1)) begin
          state_d = LONG;
          long_d  = 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
          rep_d   = '0;
`endif
        end
      end
      LONG: begin
        if (release_ev) begin
          state_d   = IDLE;
          release_d = 1'b1;
          pressed_d = 1'b0;
        end
`ifdef KEY_EVENT_REPEAT_EN
        else if (tick) begin
          if (rep_q == REP_M1) begin
            rep_d    = '0;
            repeat_d = 1'b1;
          end else begin
            rep_d = rep_q + 16'd1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= RELEASED_LEVEL;
      sync2_q   <= RELEASED_LEVEL;
      edge_q    <= RELEASED_LEVEL;
      state_q   <= IDLE;
      ps_q      <= '0;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      sync1_q   <= key_db_i;
      sync2_q   <= sync1_q;
      edge_q    <= sync2_q;
      state_q   <= state_d;
      ps_q      <= ps_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      pressed_q <= pressed_d;
    end
  end

`ifdef KEY_EVENT_REPEAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_q    <= '0;
      repeat_q <= 1'b0;
    end else begin
      rep_q    <= rep_d;
      repeat_q <= repeat_d;
    end
  end
  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign pressed_o = pressed_q;
  assign hold_ms_o = hold_q;
  assign state_o   = state_q;

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 SHALL have parameter CLK_FREQ_Hz, default 27000000, clk frequency in Hz; legal range 1000 and up.
REQ-002 SHALL have parameter RELEASED_LEVEL, default 1'b0, level of key_db_i when the key is not pressed.
REQ-003 SHALL have parameter LONG_MS, default 1000, hold time in ms before the long-press event; legal range 1..65535.
REQ-004 SHALL have parameter REPEAT_MS, default 200, auto-repeat period in ms; legal range 1..65535.
REQ-005 SHALL have port clk  input  1  system clock; the block uses one clock only.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port key_db_i  input  1  debounced key level from the debouncer, asynchronous to clk.
REQ-008 SHALL have port press_o  output  1  one-cycle pulse on each press.
REQ-009 SHALL have port release_o  output  1  one-cycle pulse on each release.
REQ-010 SHALL have port long_o  output  1  one-cycle pulse when the hold time reaches LONG_MS.
REQ-011 SHALL have port repeat_o  output  1  one-cycle pulse every REPEAT_MS while in long hold.
REQ-012 SHALL have port pressed_o  output  1  level, high from the press_o cycle up to, but not including, the release_o cycle.
REQ-013 SHALL have port hold_ms_o  output  16  whole ms elapsed since the last press.

Function
REQ-014 key_db_i SHALL pass through a 2-flop synchronizer and then a 1-flop edge register.
- A key_db_i change sampled at clk edge N produces press_o or release_o during the cycle after edge N+2.
REQ-015 Pressed SHALL mean the synchronized level differs from RELEASED_LEVEL.
REQ-016 The FSM SHALL have three states: IDLE, PRESSED and LONG.
- IDLE to PRESSED on a press edge (press_o = 1).
- PRESSED to LONG when the hold counter reaches LONG_MS (long_o = 1).
- PRESSED or LONG to IDLE on a release edge (release_o = 1).
REQ-017 An internal ms prescaler SHALL count 0..CLK_FREQ_Hz/1000-1 (integer division) and SHALL restart at 0 in the press_o cycle.
- Each wrap of the prescaler is one ms tick.
REQ-018 The hold counter (hold_ms_o) SHALL:
- clear to 0 in the press_o cycle;
- increment on each ms tick while PRESSED or LONG;
- saturate at 65535;
- freeze in IDLE until the next press.
REQ-019 long_o SHALL assert exactly LONG_MS*(CLK_FREQ_Hz/1000) cycles after press_o.
REQ-020 In LONG, repeat_o SHALL pulse every REPEAT_MS ms ticks.
- The first repeat_o comes REPEAT_MS ms after long_o.
- The repeat counter restarts at 0 on entry to LONG.
REQ-021 If a release edge occurs in the same cycle as the long or repeat threshold, release SHALL win: release_o = 1, long_o = 0, repeat_o = 0.
REQ-022 At most one of press_o, release_o, long_o and repeat_o SHALL be high in any cycle.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 While rst = 0, the block SHALL hold:
- state IDLE;
- press_o, release_o, long_o, repeat_o and pressed_o at 0;
- hold_ms_o at 0;
- prescaler and counters at 0;
- synchronizer and edge flops at RELEASED_LEVEL.
REQ-025 If the key is held through reset release, press_o SHALL pulse 3 cycles after rst deasserts; no release_o is generated for a press cut off by reset.

Configuration
REQ-026 Macro KEY_EVENT_REPEAT_EN defined: the repeat counter and repeat_o behave as in REQ-020.
REQ-027 Macro KEY_EVENT_REPEAT_EN undefined: repeat_o is tied to 0, no repeat counter is built, and REPEAT_MS is ignored; all other behaviour is unchanged.

Verification
Use CLK_FREQ_Hz=10000 (10 cycles/ms), LONG_MS=5, REPEAT_MS=2 and RELEASED_LEVEL=0 unless noted.
REQ-028 Short press: key_db_i 0->1 at edge 10, 1->0 at edge 40.
- press_o is high in the cycle after edge 12.
- release_o is high in the cycle after edge 42.
- long_o never asserts; hold_ms_o = 3 after release.
REQ-029 Long hold with macro defined: key held 100 cycles.
- long_o asserts 50 cycles after press_o.
- repeat_o asserts at +70 and +90 cycles after press_o.
- Pulses are exclusive; pressed_o stays high throughout.
REQ-030 Long hold with macro undefined: same stimulus; long_o at +50 cycles; repeat_o stays 0.
REQ-031 Release at threshold: release timed so the release edge hits the long_o cycle -> release_o = 1, long_o = 0, state IDLE.
REQ-032 Reset mid-hold: key held, rst low for 5 cycles, then high -> all outputs 0 during reset; press_o 3 cycles after rst rises; hold_ms_o restarts at 0.
REQ-033 RELEASED_LEVEL=1: key_db_i 1->0 -> press_o; 0->1 -> release_o; same latencies as REQ-028.
